spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 master shifting one DATA_W-bit frame per accepted start
// Define SPI_MASTER_LSB_FIRST_EN to shift LSB first; frame timing is identical in both builds.
module spi_master #(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              miso,
  output logic              ss,
  output logic              sclk,
  output logic              mosi,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

  logic [2:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ss_q, ss_d;
  logic              sclk_q, sclk_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] tx_shift, rx_shift;
  logic              tick;

  // mosi is taken straight from the tx register end bit, so it is a flop output
`ifdef SPI_MASTER_LSB_FIRST_EN
  assign tx_shift = {1'b0, tx_q[DATA_W-1:1]};
  assign rx_shift = {miso, rx_q[DATA_W-1:1]};
  assign mosi     = tx_q[0];
`else
  assign tx_shift = {tx_q[DATA_W-2:0], 1'b0};
  assign rx_shift = {rx_q[DATA_W-2:0], miso};
  assign mosi     = tx_q[DATA_W-1];
`endif

  assign tick     = (div_q == DIV_LAST);
  assign ss       = ss_q;
  assign sclk     = sclk_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = dout_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    ss_d    = ss_q;
    sclk_d  = sclk_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q == S_SETUP || state_q == S_SHIFT || state_q == S_HOLD) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          tx_d    = data_in;
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      S_SETUP: begin
        if (tick) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rx_d  = rx_shift;
            bit_d = bit_q + BIT_W'(1);
          end else if (bit_q == BIT_LAST) begin
            // final falling edge: mosi keeps its last bit
            state_d = S_HOLD;
          end else begin
            tx_d = tx_shift;
          end
        end
      end
      S_HOLD: begin
        if (tick) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        ss_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dout_d  = rx_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      ss_q    <= 1'b1;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      ss_q    <= ss_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule
